// File: rtl/ro_pair_compare.sv
// ro_pair_compare: gates an RO pair on, counts edges of each over a fixed window, emits the comparison bit.
module ro_pair_compare #(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             ro_release,
  output logic             busy,
  output logic             done,
  output logic             resp,
  output logic             tie,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             sat
);
  localparam int MX = WINDOW > SETTLE ? WINDOW : SETTLE;
  localparam int TW = $clog2(MX + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COUNT, S_DRAIN, S_DONE} state_t;
  state_t state;
  logic [TW-1:0] tmr;
  logic [2:0] sa, sb;
  logic [CNT_W-1:0] ca, cb;
  logic edge_a, edge_b;
  // bit 0/1 form the synchronizer, bit 2 is the delayed copy for edge detection
  assign edge_a = sa[1] & ~sa[2];
  assign edge_b = sb[1] & ~sb[2];
  assign ro_release = ro_en;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tmr   <= '0;
      sa    <= '0;
      sb    <= '0;
      ca    <= '0;
      cb    <= '0;
      ro_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      resp  <= 1'b0;
      tie   <= 1'b0;
      sat   <= 1'b0;
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      sa   <= {sa[1:0], ro_a};
      sb   <= {sb[1:0], ro_b};
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_SETTLE;
          tmr   <= TW'(SETTLE - 1);
          ro_en <= 1'b1;
          busy  <= 1'b1;
          ca    <= '0;
          cb    <= '0;
        end
        S_SETTLE: begin
          state <= tmr == '0 ? S_COUNT : S_SETTLE;
          tmr   <= tmr == '0 ? TW'(WINDOW - 1) : tmr - 1'b1;
        end
        S_COUNT: begin
          if (edge_a && ca != CMAX) ca <= ca + 1'b1;
          if (edge_b && cb != CMAX) cb <= cb + 1'b1;
          state <= tmr == '0 ? S_DRAIN : S_COUNT;
          tmr   <= tmr == '0 ? TW'(1) : tmr - 1'b1;
          ro_en <= tmr != '0;
        end
        S_DRAIN: if (tmr == '0) begin
          state <= S_DONE;
          done  <= 1'b1;
          cnt_a <= ca;
          cnt_b <= cb;
          resp  <= ca > cb;
          tie   <= ca == cb;
          sat   <= (ca == CMAX) | (cb == CMAX);
        end else tmr <= tmr - 1'b1;
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ro_pair_compare.sv
// tb_ro_pair_compare: vector table, hand sequences and random RO waveforms against a window-count model.
module tb_ro_pair_compare;
  localparam int CW = 4, W = 80, S = 4, L = S + W + 3, CM = 15;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ro_a = 1'b0, ro_b = 1'b0;
  logic ro_en, ro_release, busy, done, resp, tie, sat;
  logic [CW-1:0] cnt_a, cnt_b;
  int checks = 0, errors = 0;
  logic [CW-1:0] p_ca = '0, p_cb = '0;
  logic p_resp = 1'b0, p_tie = 1'b0, p_sat = 1'b0;

  ro_pair_compare #(.CNT_W(CW), .WINDOW(W), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .ro_release(ro_release), .busy(busy), .done(done),
    .resp(resp), .tie(tie), .cnt_a(cnt_a), .cnt_b(cnt_b), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pa, pha, pb, phb, ea, eb;
    logic resp, tie, sat;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic wave(input int j, input int p, input int ph);
    return p == 0 ? 1'b0 : ((j + ph) % p) < p / 2;
  endfunction

  // j counts negedges from the one where start is raised; an RO rise driven at
  // negedge j lands in the counter only when j is in [S-1, S+W-2]
  task automatic measure(input string nm, input int pa, input int pha, input int pb, input int phb,
                         input bit rej, input int abort_j, output int ma, output int mb);
    int dn = 0, dj = -1, en_err = 0, busy_err = 0, hold_err = 0;
    logic la = 1'b0, lb = 1'b0, va, vb;
    ma = 0;
    mb = 0;
    for (int j = 0; j <= L; j++) begin
      @(negedge clk);
      if (abort_j > 0 && j == abort_j + 1) begin
        chk({nm, " abort outputs"}, int'({ro_en, ro_release, busy, done, resp, tie, sat, cnt_a, cnt_b}), 0);
        chk({nm, " abort no done"}, dn, 0);
        rst = 1'b0;
        ro_a = 1'b0;
        ro_b = 1'b0;
        start = 1'b0;
        {p_ca, p_cb, p_resp, p_tie, p_sat} = '0;
        return;
      end
      if (done) begin
        dn++;
        dj = j;
      end
      if (ro_en !== (j >= 1 && j <= S + W) || ro_release !== ro_en) en_err++;
      if (busy !== (j >= 1)) busy_err++;
      if (j < L && {cnt_a, cnt_b, resp, tie, sat} !== {p_ca, p_cb, p_resp, p_tie, p_sat}) hold_err++;
      va = j == L ? 1'b0 : wave(j, pa, pha);
      vb = j == L ? 1'b0 : wave(j, pb, phb);
      if (j >= S - 1 && j <= S + W - 2) begin
        if (va && !la) ma++;
        if (vb && !lb) mb++;
      end
      la = va;
      lb = vb;
      ro_a = va;
      ro_b = vb;
      start = (j == 0) || (rej && (j == 2 || j == 40 || j == L));
      if (abort_j > 0 && j == abort_j) rst = 1'b1;
    end
    ma = ma > CM ? CM : ma;
    mb = mb > CM ? CM : mb;
    chk({nm, " done cycle"}, dj, L);
    chk({nm, " done count"}, dn, 1);
    chk({nm, " ro_en profile errs"}, en_err, 0);
    chk({nm, " busy profile errs"}, busy_err, 0);
    chk({nm, " result hold errs"}, hold_err, 0);
    chk({nm, " cnt_a"}, int'(cnt_a), ma);
    chk({nm, " cnt_b"}, int'(cnt_b), mb);
    chk({nm, " resp"}, int'(resp), int'(ma > mb));
    chk({nm, " tie"}, int'(tie), int'(ma == mb));
    chk({nm, " sat"}, int'(sat), int'(ma == CM || mb == CM));
    {p_ca, p_cb, p_resp, p_tie, p_sat} = {cnt_a, cnt_b, resp, tie, sat};
  endtask

  initial begin
    vec_t tv[6];
    int ma, mb, seen;
    tv[0] = '{pa: 8,  pha: 0, pb: 10, phb: 0, ea: 10, eb: 8,  resp: 1'b1, tie: 1'b0, sat: 1'b0};
    tv[1] = '{pa: 12, pha: 0, pb: 12, phb: 0, ea: 6,  eb: 6,  resp: 1'b0, tie: 1'b1, sat: 1'b0};
    tv[2] = '{pa: 4,  pha: 0, pb: 0,  phb: 0, ea: 15, eb: 0,  resp: 1'b1, tie: 1'b0, sat: 1'b1};
    tv[3] = '{pa: 6,  pha: 0, pb: 5,  phb: 0, ea: 13, eb: 15, resp: 1'b0, tie: 1'b0, sat: 1'b1};
    tv[4] = '{pa: 16, pha: 0, pb: 9,  phb: 0, ea: 5,  eb: 9,  resp: 1'b0, tie: 1'b0, sat: 1'b0};
    tv[5] = '{pa: 10, pha: 5, pb: 10, phb: 0, ea: 8,  eb: 8,  resp: 1'b0, tie: 1'b1, sat: 1'b0};

    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset outputs", int'({ro_en, ro_release, busy, done, resp, tie, sat, cnt_a, cnt_b}), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first start ro_en", int'(ro_en), 1);
    chk("first start busy", int'(busy), 1);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("first start done seen", seen, 1);
    chk("static pair tie", int'(tie), 1);
    {p_ca, p_cb, p_resp, p_tie, p_sat} = {cnt_a, cnt_b, resp, tie, sat};

    for (int i = 0; i < 6; i++) begin
      measure($sformatf("vec%0d", i), tv[i].pa, tv[i].pha, tv[i].pb, tv[i].phb, 1'b0, 0, ma, mb);
      chk($sformatf("vec%0d tbl cnt_a", i), int'(cnt_a), tv[i].ea);
      chk($sformatf("vec%0d tbl cnt_b", i), int'(cnt_b), tv[i].eb);
      chk($sformatf("vec%0d tbl flags", i), int'({resp, tie, sat}), int'({tv[i].resp, tv[i].tie, tv[i].sat}));
    end

    measure("abort", 8, 0, 10, 0, 1'b0, S + 31, ma, mb);
    measure("after abort", 8, 0, 10, 0, 1'b0, 0, ma, mb);
    chk("after abort cnt_a", int'(cnt_a), 10);
    chk("after abort cnt_b", int'(cnt_b), 8);

    measure("reject", 8, 0, 10, 0, 1'b1, 0, ma, mb);
    chk("reject cnt_a", int'(cnt_a), 10);
    chk("reject cnt_b", int'(cnt_b), 8);
    start = 1'b0;
    @(negedge clk);
    chk("reject done-cycle start busy", int'(busy), 0);

    for (int i = 0; i < 12; i++) begin
      int pa, pb;
      pa = $urandom_range(0, 5) == 0 ? 0 : int'($urandom_range(4, 20));
      pb = $urandom_range(0, 5) == 0 ? 0 : int'($urandom_range(4, 20));
      measure($sformatf("rnd%0d", i), pa, int'($urandom_range(0, 19)), pb, int'($urandom_range(0, 19)),
              1'b0, 0, ma, mb);
    end

    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("final idle busy/done", int'({busy, done, ro_en}), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
